instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams MIPS instruction-request beats into addressed 32-bit words
// One-deep output register; an illegal op is swallowed and only raises the sticky err flag.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [15:0] in_imm,
   input  logic [25:0] in_target,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        done,
   output logic        err,
   output logic [15:0] count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] ptr;
   logic [31:0] enc;
   logic        accept;
   logic        xfer;
   logic        illegal;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   assign illegal  = (in_op == 4'd15);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (accept && in_last) state_next = DRAIN;
         DRAIN:   if (!out_valid) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      done = (state == DONE);
   end

   // lui ignores rs and bgtz ignores rt, so those fields are forced to zero.
   always_comb begin
      enc = 32'h0;
      case (in_op)
         4'd0:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
         4'd1:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
         4'd2:    enc = {6'b000000, in_rs, 15'b0, 6'b001000};
         4'd3:    enc = {6'b001101, in_rs, in_rt, in_imm};
         4'd4:    enc = {6'b001111, 5'b0, in_rt, in_imm};
         4'd5:    enc = {6'b000010, in_target};
         4'd6:    enc = {6'b000011, in_target};
         4'd7:    enc = {6'b100011, in_rs, in_rt, in_imm};
         4'd8:    enc = {6'b101011, in_rs, in_rt, in_imm};
         4'd9:    enc = {6'b100000, in_rs, in_rt, in_imm};
         4'd10:   enc = {6'b100100, in_rs, in_rt, in_imm};
         4'd11:   enc = {6'b000100, in_rs, in_rt, in_imm};
         4'd12:   enc = {6'b000101, in_rs, in_rt, in_imm};
         4'd13:   enc = {6'b000111, in_rs, 5'b0, in_imm};
         4'd14:   enc = {6'b101000, in_rs, in_rt, in_imm};
         default: enc = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_instr <= 32'h0;
         out_addr  <= BASE_ADDR;
         ptr       <= BASE_ADDR;
         count     <= 16'h0;
         err       <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            ptr   <= BASE_ADDR;
            count <= 16'h0;
            err   <= 1'b0;
         end
         if (xfer) begin
            out_valid <= 1'b0;
            if (count != 16'hFFFF) count <= count + 16'd1;
         end
         // Loading a new word in the transfer cycle keeps throughput at one word per clock.
         if (accept) begin
            if (illegal) begin
               err <= 1'b1;
            end else begin
               out_valid <= 1'b1;
               out_instr <= enc;
               out_addr  <= ptr;
               ptr       <= ptr + 32'd4;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
// Directed scenarios plus randomized loads scored against an encoding table and word queue.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        in_valid;
   logic [3:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;
   logic        out_ready;
   logic        in_ready, out_valid, done, err;
   logic [31:0] out_instr, out_addr;
   logic [15:0] count;
   logic        w_in_ready, w_out_valid, w_done, w_err;
   logic [31:0] w_out_instr, w_out_addr;
   logic [15:0] w_count;

   int compares = 0;
   int errors   = 0;
   int i_opc [16] = '{0, 0, 0, 13, 15, 0, 0, 35, 43, 32, 36, 4, 5, 7, 40, 0};

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .done(done), .err(err), .count(count)
   );

   instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .in_last(in_last), .out_valid(w_out_valid), .out_ready(out_ready),
      .out_instr(w_out_instr), .out_addr(w_out_addr), .done(w_done), .err(w_err), .count(w_count)
   );

   function automatic logic [31:0] ref_enc(input logic [3:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [15:0] imm, input logic [25:0] tgt);
      logic [31:0] r, t, d;
      r = 32'(rs);
      t = 32'(rt);
      d = 32'(rd);
      case (op)
         4'd0:  return (r << 21) | (t << 16) | (d << 11) | 32'd32;
         4'd1:  return (r << 21) | (t << 16) | (d << 11) | 32'd34;
         4'd2:  return (r << 21) | 32'd8;
         4'd5:  return (32'd2 << 26) | 32'(tgt);
         4'd6:  return (32'd3 << 26) | 32'(tgt);
         4'd15: return 32'd0;
         default: begin
            if (op == 4'd4) r = 32'd0;
            if (op == 4'd13) t = 32'd0;
            return (32'(i_opc[op]) << 26) | (r << 21) | (t << 16) | 32'(imm);
         end
      endcase
   endfunction

   function automatic logic [31:0] cur_enc();
      return ref_enc(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
   endfunction

   task automatic set_beat(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                           input logic last);
      in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
      in_imm = imm; in_target = tgt; in_last = last;
   endtask

   task automatic rand_beat(input bit allow_bad);
      in_op     = (allow_bad && $urandom_range(7) == 0) ? 4'd15 : 4'($urandom_range(14));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(output int pulses);
      pulses = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         if (done) pulses++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0; in_target = 26'd0;
      repeat (2) @(negedge clk);
      #1;
      compares++;
      if ({in_ready, out_valid, done, err, count, out_instr, out_addr} !== {4'b0000, 16'h0, 32'h0, 32'h0000_3000}) begin
         errors++;
         $display("FAIL reset_state: got rdy/v/done/err=%b%b%b%b cnt=%h instr=%h addr=%h",
                  in_ready, out_valid, done, err, count, out_instr, out_addr);
      end
      compares++;
      if (w_out_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL reset_base_addr_param: got %h expected FFFFFFFC", w_out_addr);
      end
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk); #1;
      compares++;
      if ({in_ready, out_valid, done, count} !== {3'b000, 16'h0}) begin
         errors++;
         $display("FAIL idle_after_reset: got rdy=%b v=%b done=%b cnt=%h", in_ready, out_valid, done, count);
      end
   endtask

   task automatic test_add();
      int pulses;
      do_start();
      set_beat(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
      out_ready = 1'b1;
      #1;
      compares++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL add_in_ready: got %b expected 1", in_ready);
      end
      @(negedge clk); in_valid = 1'b0; #1;
      compares++;
      if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h0022_1820, 32'h0000_3000}) begin
         errors++;
         $display("FAIL add_word: got v=%b %h @%h expected 1 00221820 @00003000", out_valid, out_instr, out_addr);
      end
      wait_done(pulses);
      compares++;
      if ({pulses == 1, count, in_ready} !== {1'b1, 16'd1, 1'b0}) begin
         errors++; $display("FAIL add_done_count: got pulses=%0d cnt=%0d rdy=%b expected 1 1 0", pulses, count, in_ready);
      end
   endtask

   task automatic test_lui_bgtz();
      int pulses;
      do_start();
      set_beat(4'd4, 5'd5, 5'd8, 5'd0, 16'h1234, 26'h0, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      set_beat(4'd13, 5'd4, 5'd7, 5'd0, 16'hFFFE, 26'h0, 1'b1);
      #1;
      compares++;
      if ({out_valid, out_instr, out_addr, in_ready} !== {1'b1, 32'h3C08_1234, 32'h0000_3000, 1'b1}) begin
         errors++; $display("FAIL lui_word: got v=%b %h @%h rdy=%b expected 3C081234 @00003000", out_valid, out_instr, out_addr, in_ready);
      end
      @(negedge clk); in_valid = 1'b0; #1;
      compares++;
      if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h1C80_FFFE, 32'h0000_3004}) begin
         errors++; $display("FAIL bgtz_word: got v=%b %h @%h expected 1C80FFFE @00003004", out_valid, out_instr, out_addr);
      end
      wait_done(pulses);
      compares++;
      if ({pulses == 1, count} !== {1'b1, 16'd2}) begin
         errors++; $display("FAIL lui_bgtz_done_count: got pulses=%0d cnt=%0d expected 1 2", pulses, count);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] words [4];
      int          idx = 0;
      int          pulses;
      int          wi;
      logic        exp_rdy;
      do_start();
      for (int t = 0; t < 8; t++) begin
         if (t != 0) @(negedge clk);
         if (idx < 4) begin
            rand_beat(0);
            in_valid = 1'b1;
            in_last = (idx == 3);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = !(t >= 1 && t <= 3);
         #1;
         exp_rdy = (t == 0) || (t >= 4 && t <= 6);
         wi = (t <= 4) ? 0 : t - 4;
         compares++;
         if ({in_ready, out_valid} !== {exp_rdy, t >= 1}) begin
            errors++; $display("FAIL bp_handshake t=%0d: got rdy=%b v=%b expected %b %b", t, in_ready, out_valid, exp_rdy, t >= 1);
         end
         if (t >= 1) begin
            compares++;
            if ({out_instr, out_addr} !== {words[wi], 32'h3000 + 32'(4 * wi)}) begin
               errors++; $display("FAIL bp_word t=%0d: got %h @%h expected %h @%h", t, out_instr, out_addr, words[wi], 32'h3000 + 32'(4 * wi));
            end
         end
         if (in_valid && in_ready) begin
            words[idx] = cur_enc();
            idx++;
         end
      end
      wait_done(pulses);
      compares++;
      if ({pulses == 1, count, idx == 4} !== {1'b1, 16'd4, 1'b1}) begin
         errors++; $display("FAIL bp_done_count: got pulses=%0d cnt=%0d beats=%0d expected 1 4 4", pulses, count, idx);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] w0, w1;
      int          pulses;
      do_start();
      out_ready = 1'b1;
      set_beat(4'd8, 5'd3, 5'd9, 5'd0, 16'h0010, 26'h0, 1'b0);
      w0 = cur_enc();
      @(negedge clk);
      set_beat(4'd15, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'h0, 1'b0);
      @(negedge clk);
      set_beat(4'd8, 5'd4, 5'd10, 5'd0, 16'h0020, 26'h0, 1'b1);
      w1 = cur_enc();
      #1;
      compares++;
      if ({out_valid, err, in_ready} !== 3'b011) begin
         errors++; $display("FAIL illegal_no_word: got v=%b err=%b rdy=%b expected 0 1 1", out_valid, err, in_ready);
      end
      @(negedge clk); in_valid = 1'b0; #1;
      compares++;
      if ({out_valid, out_instr, out_addr} !== {1'b1, w1, 32'h0000_3004}) begin
         errors++; $display("FAIL illegal_addr_contig: got v=%b %h @%h expected %h @00003004", out_valid, out_instr, out_addr, w1);
      end
      wait_done(pulses);
      compares++;
      if ({pulses == 1, count, err, w0 != 32'h0} !== {1'b1, 16'd2, 1'b1, 1'b1}) begin
         errors++; $display("FAIL illegal_done_count_err: got pulses=%0d cnt=%0d err=%b expected 1 2 1", pulses, count, err);
      end
   endtask

   task automatic test_jal_wrap();
      int pulses;
      do_start();
      out_ready = 1'b1;
      set_beat(4'd6, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C01, 1'b0);
      @(negedge clk);
      set_beat(4'd0, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1);
      #1;
      compares++;
      if ({w_out_valid, w_out_instr, w_out_addr} !== {1'b1, 32'h0C00_0C01, 32'hFFFF_FFFC}) begin
         errors++; $display("FAIL jal_word: got v=%b %h @%h expected 0C000C01 @FFFFFFFC", w_out_valid, w_out_instr, w_out_addr);
      end
      @(negedge clk); in_valid = 1'b0; #1;
      compares++;
      if ({w_out_valid, w_out_instr, w_out_addr} !== {1'b1, ref_enc(4'd0, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0), 32'h0}) begin
         errors++; $display("FAIL addr_wrap: got v=%b %h @%h expected @00000000", w_out_valid, w_out_instr, w_out_addr);
      end
      wait_done(pulses);
      compares++;
      if ({w_count, w_err, w_in_ready} !== {16'd2, 1'b0, 1'b0}) begin
         errors++; $display("FAIL wrap_count: got cnt=%0d err=%b rdy=%b expected 2 0 0", w_count, w_err, w_in_ready);
      end
   endtask

   task automatic test_reset_mid();
      do_start();
      out_ready = 1'b1;
      set_beat(4'd7, 5'd1, 5'd2, 5'd0, 16'h4, 26'h0, 1'b0);
      @(negedge clk);
      set_beat(4'd9, 5'd3, 5'd4, 5'd0, 16'h8, 26'h0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      compares++;
      if ({out_valid, count} !== {1'b1, 16'd1}) begin
         errors++; $display("FAIL pre_reset_hold: got v=%b cnt=%0d expected 1 1", out_valid, count);
      end
      #1 reset_n = 1'b0;
      #1;
      compares++;
      if ({out_valid, in_ready, done, err, count, out_instr, out_addr, w_done} !== {4'b0000, 16'h0, 32'h0, 32'h0000_3000, 1'b0}) begin
         errors++; $display("FAIL async_reset_mid: got v=%b rdy=%b done=%b err=%b cnt=%h instr=%h addr=%h", out_valid, in_ready, done, err, count, out_instr, out_addr);
      end
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random(input int loads);
      for (int l = 0; l < loads; l++) begin
         logic [63:0] q[$];
         logic [31:0] ptr;
         int          n, idx, cyc, cnt, pulses;
         bit          run, merr;
         logic        exp_rdy;
         q.delete();
         ptr = 32'h0000_3000; n = $urandom_range(1, 16); idx = 0; cyc = 0; cnt = 0; run = 1; merr = 0;
         do_start();
         while ((idx < n || q.size() != 0) && cyc < 400) begin
            rand_beat(1);
            in_valid  = (idx < n) && ($urandom_range(3) != 0);
            in_last   = (idx == n - 1);
            out_ready = ($urandom_range(9) < 7);
            #1;
            exp_rdy = run && (q.size() == 0 || out_ready);
            compares++;
            if ({in_ready, out_valid, count, err} !== {exp_rdy, q.size() != 0, 16'(cnt), merr}) begin
               errors++; $display("FAIL rand_ctrl load=%0d cyc=%0d: got rdy=%b v=%b cnt=%0d err=%b expected %b %b %0d %b",
                                  l, cyc, in_ready, out_valid, count, err, exp_rdy, q.size() != 0, cnt, merr);
            end
            if (q.size() != 0) begin
               compares++;
               if ({out_instr, out_addr} !== q[0]) begin
                  errors++; $display("FAIL rand_word load=%0d cyc=%0d: got %h @%h expected %h @%h",
                                     l, cyc, out_instr, out_addr, q[0][63:32], q[0][31:0]);
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  cnt++;
               end
            end
            if (in_valid && exp_rdy) begin
               if (in_op == 4'd15) merr = 1;
               else begin
                  q.push_back({cur_enc(), ptr});
                  ptr = ptr + 32'd4;
               end
               if (in_last) run = 0;
               idx++;
            end
            cyc++;
            @(negedge clk);
         end
         in_valid = 1'b0;
         compares++;
         if (cyc >= 400) begin
            errors++; $display("FAIL rand_timeout load=%0d: got %0d cycles expected under 400", l, cyc);
         end
         wait_done(pulses);
         compares++;
         if ({pulses == 1, count, err} !== {1'b1, 16'(cnt), merr}) begin
            errors++; $display("FAIL rand_done load=%0d: got pulses=%0d cnt=%0d err=%b expected 1 %0d %b", l, pulses, count, err, cnt, merr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lui_bgtz();
      test_backpressure();
      test_illegal();
      test_jal_wrap();
      test_reset_mid();
      test_random(6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end

endmodule
